// File: rtl/bpsk_frame_sched_if.sv
// Frame scheduler bus bundle: host writer port, modulator reader port and
// the single-port frame RAM port. The scheduler uses the slave view; the
// environment (writer, modulator, RAM) uses the master view.
interface bpsk_frame_sched_if #(
  parameter int data_width = 8,
  parameter int addr_width = 8
) ();

  // Host-side frame writer
  logic                  wr_req;
  logic [addr_width-1:0] wr_addr;
  logic [data_width-1:0] wr_data;
  logic                  wr_ack;
  logic                  wr_commit;
  logic [addr_width-1:0] wr_len;
  logic                  wr_ready;

  // Modulator byte reader
  logic                  rd_req;
  logic [addr_width-1:0] rd_addr;
  logic [data_width-1:0] rd_data;
  logic                  rd_valid;

  // Single-port frame RAM, MSB of the address selects the bank
  logic                  ram_en;
  logic                  ram_we;
  logic [addr_width:0]   ram_addr;
  logic [data_width-1:0] ram_wr_data;
  logic [data_width-1:0] ram_rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, wr_commit, wr_len,
    output rd_req, rd_addr,
    output ram_rd_data,
    input  wr_ack, wr_ready, rd_data, rd_valid,
    input  ram_en, ram_we, ram_addr, ram_wr_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_commit, wr_len,
    input  rd_req, rd_addr,
    input  ram_rd_data,
    output wr_ack, wr_ready, rd_data, rd_valid,
    output ram_en, ram_we, ram_addr, ram_wr_data
  );

endinterface

// File: rtl/bpsk_frame_sched.sv
// Ping-pong frame scheduler for the BPSK modulator. Arbitrates one
// single-port frame RAM between the host writer and the modulator reader
// (reader first), tracks which of the two banks holds a committed frame,
// issues the send pulse and enforces an inter-frame gap after tx_done.
// Optional beacon mode (re-send the last frame while nothing new is
// pending) is enabled by defining BPSK_SCHED_REPEAT_EN.
module bpsk_frame_sched #(
  parameter int data_width   = 8,
  parameter int addr_width   = 8,
  parameter int frame_length = 150,
  parameter int gap_cycles   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bpsk_frame_sched_if.slave     bus,
  output logic                  send_signal,
  output logic [addr_width-1:0] tx_len,
  input  logic                  tx_done,
  output logic                  overflow
);

  localparam int GAP_W    = (gap_cycles > 2) ? $clog2(gap_cycles) : 1;
  localparam int GAP_LOAD = (gap_cycles > 0) ? gap_cycles - 1 : 0;
  localparam logic [addr_width-1:0] LEN_MAX  = addr_width'(frame_length);
  localparam logic [addr_width-1:0] LEN_ZERO = {addr_width{1'b0}};
  localparam logic [GAP_W-1:0]      GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_TX, S_GAP} state_t;

  // Longer commits are clipped to the largest frame the modulator accepts
  function automatic logic [addr_width-1:0] sat_len(input logic [addr_width-1:0] len);
    if (len > LEN_MAX) sat_len = LEN_MAX;
    else               sat_len = len;
  endfunction

  state_t                state_r;
  logic                  wr_bank_r;
  logic                  tx_bank_r;
  logic [1:0]            full_r;
  logic [addr_width-1:0] len_r [2];
  logic [GAP_W-1:0]      gap_cnt_r;
  logic                  rd_valid_r;
  logic                  wr_ready_r;

  logic                  done_s;
  logic                  commit_ok_s;
  logic                  commit_ovf_s;
  logic [1:0]            full_nxt_s;
  logic                  wr_bank_nxt_s;
  logic                  protect_nxt_s;

  // tx_done only counts while a frame is actually on air
  assign done_s        = tx_done & (state_r == S_TX);
  // wr_ready_r always mirrors "current write bank is free", so it gates commits
  assign commit_ok_s   = bus.wr_commit & wr_ready_r & (bus.wr_len != LEN_ZERO);
  assign commit_ovf_s  = bus.wr_commit & ~wr_ready_r;
  assign wr_bank_nxt_s = commit_ok_s ? ~wr_bank_r : wr_bank_r;

`ifdef BPSK_SCHED_REPEAT_EN
  logic last_valid_r;
  logic last_bank_r;
  // The most recently sent bank stays read-only so it can be re-sent
  assign protect_nxt_s = (last_valid_r | done_s) &
                         (wr_bank_nxt_s == (done_s ? tx_bank_r : last_bank_r));
`else
  assign protect_nxt_s = 1'b0;
`endif

  assign bus.rd_data  = bus.ram_rd_data;
  assign bus.rd_valid = rd_valid_r;
  assign bus.wr_ready = wr_ready_r;

  // Next bank occupancy: commit fills the write bank, tx_done frees the tx bank
  always_comb begin
    full_nxt_s = full_r;
    if (commit_ok_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (done_s) begin
      full_nxt_s[tx_bank_r] = 1'b0;
    end else begin
      full_nxt_s[tx_bank_r] = full_nxt_s[tx_bank_r];
    end
  end

  // RAM port arbitration: the real-time reader always wins, writer stalls
  always_comb begin
    bus.ram_en      = 1'b0;
    bus.ram_we      = 1'b0;
    bus.ram_addr    = {(addr_width+1){1'b0}};
    bus.ram_wr_data = {data_width{1'b0}};
    bus.wr_ack      = 1'b0;
    if (bus.rd_req) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = {tx_bank_r, bus.rd_addr};
    end else if (bus.wr_req && wr_ready_r) begin
      bus.ram_en      = 1'b1;
      bus.ram_we      = 1'b1;
      bus.ram_addr    = {wr_bank_r, bus.wr_addr};
      bus.ram_wr_data = bus.wr_data;
      bus.wr_ack      = 1'b1;
    end else begin
      bus.wr_ack = 1'b0;
    end
  end

  // Bank bookkeeping plus the send/transmit/gap sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      wr_bank_r   <= 1'b0;
      tx_bank_r   <= 1'b0;
      full_r      <= 2'b00;
      len_r[0]    <= LEN_ZERO;
      len_r[1]    <= LEN_ZERO;
      gap_cnt_r   <= GAP_ZERO;
      rd_valid_r  <= 1'b0;
      wr_ready_r  <= 1'b0;
      send_signal <= 1'b0;
      tx_len      <= LEN_ZERO;
      overflow    <= 1'b0;
`ifdef BPSK_SCHED_REPEAT_EN
      last_valid_r <= 1'b0;
      last_bank_r  <= 1'b0;
`endif
    end else begin
      rd_valid_r <= bus.rd_req;
      wr_ready_r <= ~full_nxt_s[wr_bank_nxt_s] & ~protect_nxt_s;
      full_r     <= full_nxt_s;
      wr_bank_r  <= wr_bank_nxt_s;
      if (commit_ok_s) begin
        len_r[wr_bank_r] <= sat_len(bus.wr_len);
      end
      if (commit_ovf_s) begin
        overflow <= 1'b1;
      end
`ifdef BPSK_SCHED_REPEAT_EN
      if (done_s) begin
        last_valid_r <= 1'b1;
        last_bank_r  <= tx_bank_r;
      end
`endif
      case (state_r)
        S_IDLE: begin
          if (full_r[tx_bank_r]) begin
            send_signal <= 1'b1;
            tx_len      <= len_r[tx_bank_r];
            state_r     <= S_SEND;
          end
`ifdef BPSK_SCHED_REPEAT_EN
          else if (last_valid_r) begin
            tx_bank_r   <= last_bank_r;
            send_signal <= 1'b1;
            tx_len      <= len_r[last_bank_r];
            state_r     <= S_SEND;
          end
`endif
        end
        S_SEND: begin
          send_signal <= 1'b0;
          state_r     <= S_TX;
        end
        S_TX: begin
          if (done_s) begin
            tx_bank_r <= ~tx_bank_r;
            gap_cnt_r <= GAP_W'(GAP_LOAD);
            state_r   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_r == GAP_ZERO) begin
            state_r <= S_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_ONE;
          end
        end
        default: begin
          send_signal <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_frame_sched.sv
// Self-checking bench for bpsk_frame_sched: behavioural frame RAM, read-data
// scoreboard and one task per scenario. Inputs change on the falling edge,
// registered outputs are sampled there, combinational outputs #1 later.
module tb_bpsk_frame_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send_signal;
  logic [7:0] tx_len;
  logic       tx_done;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem     [0:511];
  logic [7:0] exp_mem [0:511];
  logic [7:0] ram_q;
  logic [7:0] sb_q [$];

  bpsk_frame_sched_if #(.data_width(8), .addr_width(8)) bus ();

  bpsk_frame_sched #(
    .data_width(8), .addr_width(8), .frame_length(150), .gap_cycles(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .send_signal(send_signal),
    .tx_len(tx_len), .tx_done(tx_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with one cycle read latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q <= 8'h00;
    end else begin
      if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wr_data;
      if (bus.ram_en && !bus.ram_we) ram_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rd_data = ram_q;

  task automatic test_reset();
    rst_n = 1'b0; tx_done = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = 8'h00; bus.wr_data = 8'h00;
    bus.wr_commit = 1'b0; bus.wr_len = 8'h00;
    bus.rd_req = 1'b0; bus.rd_addr = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({send_signal, overflow, bus.wr_ack, bus.wr_ready, bus.rd_valid, bus.ram_en, bus.ram_we} !== 7'b0)
      begin miscompares++; $display("FAIL reset_flags: got %b want 0000000", {send_signal, overflow, bus.wr_ack, bus.wr_ready, bus.rd_valid, bus.ram_en, bus.ram_we}); end
    vectors++;
    if (tx_len !== 8'h00 || bus.ram_addr !== 9'h000 || bus.rd_data !== 8'h00)
      begin miscompares++; $display("FAIL reset_buses: got tx_len=%h ram_addr=%h rd_data=%h want 0", tx_len, bus.ram_addr, bus.rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
  endtask

  task automatic test_write_commit();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wr_req = 1'b1; bus.wr_addr = 8'(i); bus.wr_data = 8'h10 + 8'(i);
      exp_mem[9'(i)] = 8'h10 + 8'(i);
      #1;
      vectors++;
      if ({bus.wr_ack, bus.ram_en, bus.ram_we} !== 3'b111 || bus.ram_addr !== {1'b0, 8'(i)})
        begin miscompares++; $display("FAIL write_grant: got ack/en/we=%b addr=%h want 111 addr=%h", {bus.wr_ack, bus.ram_en, bus.ram_we}, bus.ram_addr, {1'b0, 8'(i)}); end
    end
    @(negedge clk);
    bus.wr_req = 1'b0; bus.wr_commit = 1'b1; bus.wr_len = 8'd4;
    @(negedge clk);
    bus.wr_commit = 1'b0;
    vectors++;
    if (send_signal !== 1'b0 || bus.wr_ready !== 1'b1)
      begin miscompares++; $display("FAIL commit_next: got send=%b wr_ready=%b want send=0 wr_ready=1", send_signal, bus.wr_ready); end
    @(negedge clk);
    vectors++;
    if (send_signal !== 1'b1 || tx_len !== 8'd4)
      begin miscompares++; $display("FAIL first_send: got send=%b tx_len=%0d want send=1 tx_len=4", send_signal, tx_len); end
    @(negedge clk);
    vectors++;
    if (send_signal !== 1'b0) begin miscompares++; $display("FAIL send_width: got %b want 0", send_signal); end
  endtask

  task automatic test_arbitration();
    logic [7:0] exp;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 8'd2;
    bus.wr_req = 1'b1; bus.wr_addr = 8'd0; bus.wr_data = 8'hA5;
    sb_q.push_back(exp_mem[9'd2]);
    #1;
    vectors++;
    if ({bus.ram_en, bus.ram_we, bus.wr_ack} !== 3'b100 || bus.ram_addr !== 9'h002)
      begin miscompares++; $display("FAIL arb_reader_first: got en/we/ack=%b addr=%h want 100 addr=002", {bus.ram_en, bus.ram_we, bus.wr_ack}, bus.ram_addr); end
    @(negedge clk);
    vectors++;
    if (!bus.rd_valid || sb_q.size() == 0) begin miscompares++; $display("FAIL arb_rd_valid: got rd_valid=%b want 1", bus.rd_valid); end
    else begin
      exp = sb_q.pop_front();
      if (bus.rd_data !== exp) begin miscompares++; $display("FAIL arb_rd_data: got %h want %h", bus.rd_data, exp); end
    end
    bus.rd_req = 1'b0;
    exp_mem[9'h100] = 8'hA5;
    #1;
    vectors++;
    if ({bus.wr_ack, bus.ram_we} !== 2'b11 || bus.ram_addr !== 9'h100)
      begin miscompares++; $display("FAIL arb_write_after: got ack/we=%b addr=%h want 11 addr=100", {bus.wr_ack, bus.ram_we}, bus.ram_addr); end
    @(negedge clk);
    bus.wr_req = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_drop: got %b want 0", bus.rd_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (!bus.rd_valid || sb_q.size() == 0) begin miscompares++; $display("FAIL burst_valid: got rd_valid=%b want 1", bus.rd_valid); end
        else begin
          exp = sb_q.pop_front();
          if (bus.rd_data !== exp) begin miscompares++; $display("FAIL burst_data: got %h want %h", bus.rd_data, exp); end
        end
      end
      bus.rd_req = 1'b1; bus.rd_addr = 8'(3 - i);
      sb_q.push_back(exp_mem[9'(3 - i)]);
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    vectors++;
    if (!bus.rd_valid || sb_q.size() == 0) begin miscompares++; $display("FAIL burst_last_valid: got rd_valid=%b want 1", bus.rd_valid); end
    else begin
      exp = sb_q.pop_front();
      if (bus.rd_data !== exp) begin miscompares++; $display("FAIL burst_last_data: got %h want %h", bus.rd_data, exp); end
    end
  endtask

  task automatic test_overflow();
    bit early = 1'b0;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      bus.wr_req = 1'b1; bus.wr_addr = 8'(i); bus.wr_data = 8'h20 + 8'(i);
      #1;
      vectors++;
      if (bus.wr_ack !== 1'b1 || bus.ram_addr !== {1'b1, 8'(i)})
        begin miscompares++; $display("FAIL bank1_write: got ack=%b addr=%h want ack=1 addr=%h", bus.wr_ack, bus.ram_addr, {1'b1, 8'(i)}); end
    end
    @(negedge clk);
    bus.wr_req = 1'b0; bus.wr_commit = 1'b1; bus.wr_len = 8'd6;
    @(negedge clk);
    bus.wr_commit = 1'b0;
    vectors++;
    if (bus.wr_ready !== 1'b0 || overflow !== 1'b0)
      begin miscompares++; $display("FAIL both_full: got wr_ready=%b overflow=%b want 0 0", bus.wr_ready, overflow); end
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = 8'd7; bus.wr_data = 8'h77;
    #1;
    vectors++;
    if (bus.wr_ack !== 1'b0 || bus.ram_en !== 1'b0)
      begin miscompares++; $display("FAIL write_full_bank: got ack=%b en=%b want 0 0", bus.wr_ack, bus.ram_en); end
    bus.wr_req = 1'b0; bus.wr_commit = 1'b1; bus.wr_len = 8'd3;
    @(negedge clk);
    bus.wr_commit = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || bus.wr_ready !== 1'b0)
      begin miscompares++; $display("FAIL third_commit: got overflow=%b wr_ready=%b want 1 0", overflow, bus.wr_ready); end
    repeat (4) begin
      @(negedge clk);
      if (send_signal !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early) begin miscompares++; $display("FAIL no_send_in_tx: got send_signal=1 want 0"); end
  endtask

  task automatic test_gap();
    bit early = 1'b0;
    @(negedge clk);
    tx_done = 1'b1;
    for (int j = 1; j < 18; j++) begin
      @(negedge clk);
      if (send_signal !== 1'b0) early = 1'b1;
      tx_done = (j == 5);
    end
    @(negedge clk);
    tx_done = 1'b0;
    vectors++;
    if (early) begin miscompares++; $display("FAIL gap_early_send: got send_signal=1 during gap want 0"); end
    vectors++;
    if (send_signal !== 1'b1 || tx_len !== 8'd6)
      begin miscompares++; $display("FAIL gap_send: got send=%b tx_len=%0d want send=1 tx_len=6", send_signal, tx_len); end
    vectors++;
`ifdef BPSK_SCHED_REPEAT_EN
    if (overflow !== 1'b1 || bus.wr_ready !== 1'b0)
      begin miscompares++; $display("FAIL after_done: got overflow=%b wr_ready=%b want 1 0", overflow, bus.wr_ready); end
`else
    if (overflow !== 1'b1 || bus.wr_ready !== 1'b1)
      begin miscompares++; $display("FAIL after_done: got overflow=%b wr_ready=%b want 1 1", overflow, bus.wr_ready); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit resend = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({send_signal, overflow, bus.wr_ready, bus.rd_valid, bus.ram_en} !== 5'b0 || tx_len !== 8'h00)
      begin miscompares++; $display("FAIL mid_reset: got flags=%b tx_len=%h want 00000 00", {send_signal, overflow, bus.wr_ready, bus.rd_valid, bus.ram_en}, tx_len); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (send_signal !== 1'b0) resend = 1'b1;
    end
    vectors++;
    if (resend || bus.wr_ready !== 1'b1)
      begin miscompares++; $display("FAIL post_reset_idle: got resend=%b wr_ready=%b want 0 1", resend, bus.wr_ready); end
  endtask

  task automatic test_length();
    bit sent = 1'b0;
    @(negedge clk);
    bus.wr_commit = 1'b1; bus.wr_len = 8'd0;
    repeat (6) begin
      @(negedge clk);
      bus.wr_commit = 1'b0;
      if (send_signal !== 1'b0) sent = 1'b1;
    end
    vectors++;
    if (sent || bus.wr_ready !== 1'b1)
      begin miscompares++; $display("FAIL zero_len: got sent=%b wr_ready=%b want 0 1", sent, bus.wr_ready); end
    bus.wr_commit = 1'b1; bus.wr_len = 8'd200;
    @(negedge clk);
    bus.wr_commit = 1'b0;
    vectors++;
    if (send_signal !== 1'b0) begin miscompares++; $display("FAIL sat_early: got send=%b want 0", send_signal); end
    @(negedge clk);
    vectors++;
    if (send_signal !== 1'b1 || tx_len !== 8'd150 || bus.wr_ready !== 1'b1)
      begin miscompares++; $display("FAIL sat_len: got send=%b tx_len=%0d wr_ready=%b want 1 150 1", send_signal, tx_len, bus.wr_ready); end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_arbitration();
    test_overflow();
    test_gap();
    test_reset_mid_frame();
    test_length();
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
